dizy_state_loader: RTL
======================

# dizy_state_loader

Upstream feeder for the DIZY permutation layer. It accepts the cipher state as a valid/ready stream of 5-bit chunks and assembles each complete PERM_SIZE-bit state. It then presents that state as one parallel word on a valid/ready output, which drives the permutation input. A one-state skid buffer lets the next state load while the previous one is still waiting on the output.

## Interface
- PERM_SIZE, `PERM_SIZE: state width; legal values are 30 and 40.
- CHUNK_W, 5: chunk width; fixed at 5; PERM_SIZE must be a multiple of it.
- NUM_CHUNKS, PERM_SIZE/CHUNK_W: chunks per state (6 or 8); derived, not to be overridden.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input chunk valid.
- s_ready  out  1  loader can accept a chunk.
- s_data  in  CHUNK_W  state chunk; the first chunk of a state carries state bits [PERM_SIZE-1 -: 5].
- s_last  in  1  marks the final chunk of a state.
- m_valid  out  1  assembled state valid.
- m_ready  in  1  downstream (permutation stage) accepts.
- m_data  out  PERM_SIZE  assembled state; MSB is DIZY bit 0.
- err_frame  out  1  sticky framing error.
- clr_err  in  1  synchronous clear of err_frame.

## Operation
- Chunk handshake: a chunk is accepted when s_valid && s_ready.
- Chunk counter `idx` runs 0..NUM_CHUNKS-1, width $clog2(NUM_CHUNKS).
- Chunk k is written to assembly bits [PERM_SIZE-1-5k -: 5], so the first chunk lands in the MSBs.
- Final chunk (idx == NUM_CHUNKS-1, accepted, s_last = 1):
  - If the output register is free this cycle (!m_valid || m_ready), the full state goes directly into m_data and m_valid is 1 on the next cycle.
  - Otherwise the full state stays in the assembly register and asm_full is set.
  - In both cases idx returns to 0.
- Skid transfer: when asm_full && (!m_valid || m_ready), the assembly contents move to m_data, m_valid becomes 1 and asm_full clears.
- s_ready = !asm_full (combinational).
- Output handshake: m_valid holds and m_data is stable until m_valid && m_ready. After that handshake, m_valid drops unless a new state loads on the same edge.
- Framing errors set err_frame, discard the partial state, and return idx to 0; m_valid is unaffected:
  - s_last = 1 accepted at idx < NUM_CHUNKS-1.
  - s_last = 0 accepted at idx == NUM_CHUNKS-1.
- err_frame stays set until clr_err. If clr_err and a new error occur in the same cycle, err_frame stays 1 (set wins).
- Reset, asynchronous and possibly mid-frame: idx=0, asm_full=0, m_valid=0, m_data=0, err_frame=0, assembly register=0. s_ready=1 during and after reset. Any partial or buffered state is lost.

## Timing
- Latency: final chunk accepted at edge t, output free → m_valid=1 after edge t (one cycle).
- Throughput: one chunk per cycle sustained with m_ready=1, so one state per NUM_CHUNKS cycles with no bubbles.
- Backpressure: with m_valid=1 and m_ready=0, the loader still accepts one further complete state, then holds s_ready=0.
- Recovery from backpressure: s_ready returns to 1 the cycle after the edge where the skid transfer occurs.
- No combinational path from s_valid or s_data to m_* outputs.
- Combinational paths: m_ready → s_ready is not combinational (s_ready depends only on asm_full). m_ready → internal transfer enable is combinational.

## Test plan
- PERM_SIZE=30, m_ready=1; chunks 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles, s_last on the sixth → one cycle later m_valid=1 with m_data=30'h022190A6 for exactly one cycle.
- PERM_SIZE=40, m_ready=0, two back-to-back frames A then B:
  - After frame A, m_valid=1 with m_data=A; after frame B, s_ready=0.
  - Raise m_ready for one cycle → A is taken, m_data=B on the next cycle, s_ready=1 one cycle after the transfer.
- PERM_SIZE=30; s_last asserted on the 3rd chunk → err_frame=1, no m_valid. The next 6 correctly framed chunks produce a correct state. clr_err → err_frame=0 next cycle.
- PERM_SIZE=30; 6 chunks with s_last=0 → err_frame=1 and the state is discarded. clr_err and a new s_last-early error in the same cycle → err_frame stays 1.
- Reset asserted after 4 of 6 chunks:
  - All outputs return to reset values immediately (asynchronously).
  - After release, a full 6-chunk frame yields exactly that frame's data, with no residue from the aborted chunks.
- Sustained stream of 10 frames with m_ready=1 → 10 output states, with m_valid pulses exactly NUM_CHUNKS cycles apart and s_ready constantly 1.

Source files
------------

// File: rtl/dizy_state_loader.sv
// Assembles a DIZY permutation state from a stream of 5-bit chunks and presents it
// as one parallel word, with a one-state skid buffer behind the output register.
`ifndef PERM_SIZE
`define PERM_SIZE 30
`endif

module dizy_state_loader #(
    parameter int PERM_SIZE = `PERM_SIZE,
    parameter int CHUNK_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CHUNK_W-1:0]   s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PERM_SIZE-1:0] m_data,
    output logic                 err_frame,
    input  logic                 clr_err
);

    localparam int NUM_CHUNKS = PERM_SIZE / CHUNK_W;
    localparam int IDX_W      = $clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    logic [IDX_W-1:0]     idx;
    logic [PERM_SIZE-1:0] asm_q;
    logic [PERM_SIZE-1:0] asm_ins;
    logic                 asm_full;
    logic                 accept;
    logic                 at_last;
    logic                 out_free;
    logic                 frame_done;
    logic                 frame_err;
    logic                 skid_xfer;

    // s_ready depends only on the skid flag, never on m_ready.
    assign s_ready    = !asm_full;
    assign accept     = s_valid && s_ready;
    assign at_last    = (idx == LAST_IDX);
    assign out_free   = !m_valid || m_ready;
    assign frame_done = accept && at_last && s_last;
    assign frame_err  = accept && (at_last != s_last);
    assign skid_xfer  = asm_full && out_free;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        asm_ins = asm_q;
        asm_ins[PERM_SIZE-1-CHUNK_W*int'(idx) -: CHUNK_W] = s_data;
    end

    // Chunk counter and assembly/skid register. Final chunk never coincides with a skid
    // transfer because s_ready is low while the skid holds a state.
    // NOTE: the assembly register is reset like any other flop so an aborted frame leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            asm_q    <= '0;
            asm_full <= 1'b0;
        end else begin
            if (skid_xfer) begin
                asm_full <= 1'b0;
            end
            if (frame_err) begin
                idx   <= '0;
                asm_q <= '0;
            end else if (frame_done) begin
                idx <= '0;
                if (!out_free) begin
                    asm_q    <= asm_ins;
                    asm_full <= 1'b1;
                end
            end else if (accept) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                asm_q <= asm_ins;
                idx   <= idx + 1'b1;
            end
        end
    end

    // Output register: a completed frame bypasses the skid when the output is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (frame_done && out_free) begin
            m_valid <= 1'b1;
            m_data  <= asm_ins;
        end else if (skid_xfer) begin
            m_valid <= 1'b1;
            m_data  <= asm_q;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Sticky framing error; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_frame <= 1'b0;
        end else if (frame_err) begin
            err_frame <= 1'b1;
        end else if (clr_err) begin
            err_frame <= 1'b0;
        end
    end

endmodule
